// File: rtl/logicnet_layer_sequencer_if.sv
// Config, input-vector and output-vector signals for one time-multiplexed LogicNets layer.
// master = the side driving stimulus and config; slave = the sequencer.
interface logicnet_layer_sequencer_if #(
    parameter int IN_WIDTH = 8,
    parameter int NEURONS  = 4,
    parameter int FANIN    = 2,
    parameter int IDX_W    = 3
);
    localparam int NEU_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

    logic              cfg_tt_we;
    logic [NEU_W-1:0]  cfg_tt_neuron;
    logic [FANIN-1:0]  cfg_tt_addr;
    logic              cfg_tt_bit;
    logic              cfg_conn_we;
    logic [NEU_W-1:0]  cfg_conn_neuron;
    logic [SLOT_W-1:0] cfg_conn_slot;
    logic [IDX_W-1:0]  cfg_conn_idx;
    logic              cfg_ready;

    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;

    logic               out_valid;
    logic               out_ready;
    logic [NEURONS-1:0] out_data;
    logic               busy;

    modport master (
        output cfg_tt_we, cfg_tt_neuron, cfg_tt_addr, cfg_tt_bit,
        output cfg_conn_we, cfg_conn_neuron, cfg_conn_slot, cfg_conn_idx,
        input  cfg_ready,
        output in_valid, in_data,
        input  in_ready,
        output out_ready,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  cfg_tt_we, cfg_tt_neuron, cfg_tt_addr, cfg_tt_bit,
        input  cfg_conn_we, cfg_conn_neuron, cfg_conn_slot, cfg_conn_idx,
        output cfg_ready,
        input  in_valid, in_data,
        output in_ready,
        input  out_ready,
        output out_valid, out_data, busy
    );
endinterface

// File: rtl/logicnet_layer_sequencer.sv
// Evaluates one LogicNets sparse layer a neuron per clock through a single shared
// truth-table lookup, using distributed config memories loaded while idle.
//
// state | meaning
// IDLE  | accepting config writes and a new input vector
// EVAL  | neuron n looked up and written to out_data[n] each cycle
// DONE  | out_data presented, held until downstream takes it
module logicnet_layer_sequencer #(
    parameter int IN_WIDTH = 8,
    parameter int NEURONS  = 4,
    parameter int FANIN    = 2,
    parameter int IDX_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    logicnet_layer_sequencer_if.slave   bus
);
    localparam int NEU_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int TT_SIZE = 1 << FANIN;
    localparam int PAD_W   = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IN_WIDTH-1:0] in_reg;
    logic [NEU_W-1:0]    n;
    logic [NEURONS-1:0]  out_data_r;

    logic [TT_SIZE-1:0] tt   [NEURONS];
    logic [IDX_W-1:0]   conn [NEURONS][FANIN];

    logic [PAD_W-1:0] in_pad;
    logic [FANIN-1:0] addr;
    logic             lut_bit;
    logic             last;
    logic             accept;
    logic             idle_open;

    // Zero-padding the captured vector makes any out-of-range index read as 0.
    always_comb begin
        in_pad = '0;
        in_pad[IN_WIDTH-1:0] = in_reg;
        addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            addr[k] = in_pad[conn[n][k]];
        end
        lut_bit = tt[n][addr];
    end

    assign last = (n == NEU_W'(NEURONS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        idle_open     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                idle_open     = !rst;
                bus.in_ready  = !rst;
                bus.cfg_ready = !rst;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                bus.busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n          <= '0;
            out_data_r <= '0;
        end else if (accept) begin
            in_reg <= bus.in_data;
            n      <= '0;
        end else if (state == EVAL) begin
            out_data_r[n] <= lut_bit;
            n             <= last ? '0 : n + 1'b1;
        end
    end

    // Config memories are intentionally unreset so a layer reset keeps the programmed network.
    always_ff @(posedge clk) begin
        if (idle_open && bus.cfg_tt_we) begin
            tt[bus.cfg_tt_neuron][bus.cfg_tt_addr] <= bus.cfg_tt_bit;
        end
        if (idle_open && bus.cfg_conn_we) begin
            conn[bus.cfg_conn_neuron][bus.cfg_conn_slot] <= bus.cfg_conn_idx;
        end
    end

    assign bus.out_data = out_data_r;

endmodule

// File: tb/tb_logicnet_layer_sequencer.sv
// Scoreboard bench for logicnet_layer_sequencer: a reference model predicts each
// layer output when a vector is accepted; a monitor compares on the output handshake.
module tb_logicnet_layer_sequencer;
    localparam int IN_WIDTH = 8;
    localparam int NEURONS  = 4;
    localparam int FANIN    = 2;
    localparam int IDX_W    = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errs = 0;
    int   nchk = 0;

    logic [3:0] exp_q [$];
    logic [3:0] m_tt [4];
    int         m_conn [4][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logicnet_layer_sequencer_if #(
        .IN_WIDTH(IN_WIDTH), .NEURONS(NEURONS), .FANIN(FANIN), .IDX_W(IDX_W)
    ) bus ();

    logicnet_layer_sequencer #(
        .IN_WIDTH(IN_WIDTH), .NEURONS(NEURONS), .FANIN(FANIN), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [7:0] d);
        logic [3:0] r;
        logic [1:0] a;
        r = '0;
        for (int nn = 0; nn < 4; nn++) begin
            a = '0;
            for (int k = 0; k < 2; k++) begin
                a[k] = (m_conn[nn][k] < IN_WIDTH) ? d[m_conn[nn][k]] : 1'b0;
            end
            r[nn] = m_tt[nn][a];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic write_tt_bit(input int nn, input int a, input logic v, input bit lands);
        bus.cfg_tt_we     = 1'b1;
        bus.cfg_tt_neuron = nn[1:0];
        bus.cfg_tt_addr   = a[1:0];
        bus.cfg_tt_bit    = v;
        @(negedge clk);
        bus.cfg_tt_we = 1'b0;
        if (lands) m_tt[nn][a] = v;
    endtask

    task automatic write_tt(input int nn, input logic [3:0] v, input bit lands);
        for (int a = 0; a < 4; a++) write_tt_bit(nn, a, v[a], lands);
    endtask

    task automatic write_conn(input int nn, input int slot, input int idx);
        bus.cfg_conn_we     = 1'b1;
        bus.cfg_conn_neuron = nn[1:0];
        bus.cfg_conn_slot   = slot[0:0];
        bus.cfg_conn_idx    = idx[2:0];
        @(negedge clk);
        bus.cfg_conn_we = 1'b0;
        m_conn[nn][slot] = idx;
    endtask

    task automatic send(input logic [7:0] d, input bit expect_out);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
        else if (expect_out) exp_q.push_back(model(d));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) check("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int prev;
        int t;
        int highs;

        rst = 1'b1;
        bus.cfg_tt_we = 0; bus.cfg_tt_neuron = 0; bus.cfg_tt_addr = 0; bus.cfg_tt_bit = 0;
        bus.cfg_conn_we = 0; bus.cfg_conn_neuron = 0; bus.cfg_conn_slot = 0; bus.cfg_conn_idx = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_cfg_ready", 32'(bus.cfg_ready), 32'd1);

        // n0 AND(in0,in1), n1 OR(in2,in3), n2 XOR(in4,in5), n3 AND(in6,in7)
        write_tt(0, 4'b1000, 1);
        write_tt(1, 4'b1110, 1);
        write_tt(2, 4'b0110, 1);
        write_tt(3, 4'b1000, 1);
        for (int nn = 0; nn < 4; nn++) begin
            write_conn(nn, 0, 2 * nn);
            write_conn(nn, 1, 2 * nn + 1);
        end

        send(8'h27, 1);
        wait_out(lat);
        check("latency", 32'(lat), 32'd4);
        check("func_27", 32'(bus.out_data), 32'h7);
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.out_valid), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);

        // back-to-back with in_valid held high
        bus.in_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            bus.in_data = i[7:0];
            t = 0;
            while (!bus.in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!bus.in_ready) check("exh_accept_timeout", 32'd0, 32'd1);
            else begin
                exp_q.push_back(model(i[7:0]));
                if (i > 0) check("spacing", 32'(cyc - prev), 32'd6);
                prev = cyc;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();
        @(negedge clk);

        // backpressure
        bus.out_ready = 1'b0;
        send(8'h27, 1);
        wait_out(lat);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'h7);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = (c == 3);
            bus.in_data  = 8'hFF;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
        check("bp_data_held", 32'(bus.out_data), 32'h7);
        check("bp_idle_busy", 32'(bus.busy), 32'd0);

        // config lockout: writes during EVAL must be dropped
        send(8'h27, 1);
        write_tt(2, 4'hF, 0);
        wait_out(lat);
        check("lockout_cur", 32'(bus.out_data), 32'h7);
        @(negedge clk);
        send(8'h27, 1);
        wait_out(lat);
        check("lockout_rerun", 32'(bus.out_data), 32'h7);
        @(negedge clk);
        send(8'h00, 1);
        wait_out(lat);
        check("lockout_00", 32'(bus.out_data), 32'h0);
        @(negedge clk);

        // simultaneous config write and acceptance: n0 tt -> 4'b0001
        write_tt_bit(0, 0, 1'b1, 1);
        bus.cfg_tt_we     = 1'b1;
        bus.cfg_tt_neuron = 2'd0;
        bus.cfg_tt_addr   = 2'd3;
        bus.cfg_tt_bit    = 1'b0;
        m_tt[0][3] = 1'b0;
        send(8'h27, 1);
        bus.cfg_tt_we = 1'b0;
        wait_out(lat);
        check("simul", 32'(bus.out_data), 32'h6);
        @(negedge clk);
        write_tt(0, 4'b1000, 1);

        // reset two cycles after acceptance
        send(8'h27, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        rst = 1'b0;
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("mid_rst_in_ready_back", 32'(bus.in_ready), 32'd1);
        highs = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) highs++;
            @(negedge clk);
        end
        check("mid_rst_no_valid", 32'(highs), 32'd0);
        send(8'h27, 1);
        wait_out(lat);
        check("rerun_after_rst", 32'(bus.out_data), 32'h7);
        @(negedge clk);

        drain();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
